// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - rv32i_types writeback/CDB packet types and arbiter constants
package rv32i_types;

  localparam int NUM_WB_REQ      = 4;
  localparam int WB_REQ_LOAD     = 0;
  localparam int WB_REQ_DIV      = 1;
  localparam int WB_REQ_MUL      = 2;
  localparam int WB_REQ_ALU      = 3;
  localparam int WB_STARVE_LIMIT = 7;
  localparam int WB_AGE_W        = $clog2(WB_STARVE_LIMIT + 1);

  typedef struct packed {
    logic [31:0] monitor_pc_rdata;
    logic [31:0] monitor_rd_wdata;
    logic [4:0]  monitor_rd_addr;
  } rvfi_pkt_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  p_addr;
    logic [4:0]  rd_aaddr;
    logic [31:0] rd_data;
    logic [3:0]  rob_idx;
    rvfi_pkt_t   rvfi_pkt;
    logic [3:0]  br_bmask;
    logic [31:0] pc_next;
    logic        br_en;
    logic        br_mispred;
    logic [3:0]  br_bit;
    logic        prediction;
    logic [7:0]  pht_index;
    logic        is_branch;
  } wb_pkt_t;

  typedef struct packed {
    logic        cdb_broadcast;
    logic [5:0]  p_addr;
    logic [4:0]  aaddr;
    logic [31:0] cdb_rd;
    logic [3:0]  rob_idx;
    rvfi_pkt_t   rvfi_pkt;
    logic [3:0]  br_bmask;
    logic [31:0] pc_next;
    logic        br_en;
    logic        br_mispred;
    logic [3:0]  br_bit;
    logic        prediction;
    logic [7:0]  pht_index;
    logic        is_branch;
  } cdb_pkt_t;

  // x0 writes never carry data onto the bus; loads report the forced value to rvfi
  function automatic cdb_pkt_t wb_to_cdb(input wb_pkt_t p, input logic is_load, input logic is_br);
    cdb_pkt_t c;
    c               = '0;
    c.cdb_broadcast = 1'b1;
    c.p_addr        = p.p_addr;
    c.aaddr         = p.rd_aaddr;
    c.cdb_rd        = (p.rd_aaddr == 5'd0) ? 32'd0 : p.rd_data;
    c.rob_idx       = p.rob_idx;
    c.rvfi_pkt      = p.rvfi_pkt;
    if (is_load) c.rvfi_pkt.monitor_rd_wdata = c.cdb_rd;
    c.br_bmask      = p.br_bmask;
    c.pc_next       = p.pc_next;
    c.br_en         = p.br_en;
    if (is_br) begin
      c.br_mispred = p.br_mispred;
      c.br_bit     = p.br_bit;
      c.prediction = p.prediction;
      c.pht_index  = p.pht_index;
      c.is_branch  = p.is_branch;
    end
    return c;
  endfunction

endpackage

// File: rtl/cdb_arbiter_age_pick.sv
// rtl/cdb_arbiter_age_pick.sv - cdb_age_pick: starved-first, lowest-index-first one-hot pick of two
module cdb_age_pick
  #(parameter int N = 4)
  (
  input  logic [N-1:0] occ,
  input  logic [N-1:0] starved,
  input  logic [N-1:0] kill,
  output logic [N-1:0] gnt0,
  output logic [N-1:0] gnt1
);

  function automatic logic [N-1:0] first_of(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] pick(input logic [N-1:0] e, input logic [N-1:0] s);
    return (|(e & s)) ? first_of(e & s) : first_of(e);
  endfunction

  logic [N-1:0] elig;

  always_comb begin
    elig = occ & ~kill;
    gnt0 = pick(elig, starved);
    gnt1 = pick(elig & ~gnt0, starved);
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - writeback holding slots and dual-CDB scheduler with aging and branch kill
// Optional: CDB_SHARE_EN lets general overflow use cdb_pkt2 when the branch slot is empty.
module cdb_arbiter
  import rv32i_types::*;
  #(
  parameter int NUM_REQ      = NUM_WB_REQ,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
  )
  (
  input  logic               clk,
  input  logic               rst_n,
  input  wb_pkt_t            req_pkt [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  input  wb_pkt_t            br_pkt,
  output logic               br_ready,
  output cdb_pkt_t           cdb_pkt,
  output cdb_pkt_t           cdb_pkt2
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
`ifdef CDB_SHARE_EN
  localparam bit SHARE_EN = 1'b1;
`else
  localparam bit SHARE_EN = 1'b0;
`endif

  wb_pkt_t            slot [NUM_REQ];
  logic [AGE_W-1:0]   age  [NUM_REQ];
  logic [NUM_REQ-1:0] occ;
  wb_pkt_t            br_slot;
  logic               br_occ;

  logic               mispred;
  logic [3:0]         clr_mask;
  logic [NUM_REQ-1:0] kill, in_kill, starved;
  logic [NUM_REQ-1:0] gnt0, gnt1, gnt2, gnt;

  // Resolution always comes from the branch broadcast of this same cycle
  always_comb begin
    mispred  = br_occ && br_slot.br_mispred;
    clr_mask = (br_occ && !br_slot.br_mispred) ? br_slot.br_bit : 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      kill[i]    = occ[i] && mispred && (|(slot[i].br_bmask & br_slot.br_bit));
      in_kill[i] = mispred && (|(req_pkt[i].br_bmask & br_slot.br_bit));
      starved[i] = (age[i] == AGE_W'(STARVE_LIMIT));
    end
  end

  cdb_age_pick #(.N(NUM_REQ)) u_pick (
    .occ     (occ),
    .starved (starved),
    .kill    (kill),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  always_comb begin
    gnt2      = (SHARE_EN && !br_occ) ? gnt1 : '0;
    gnt       = gnt0 | gnt2;
    req_ready = ~occ | gnt | kill | in_kill;
    br_ready  = !br_occ || br_occ;
  end

  always_comb begin
    cdb_pkt  = '0;
    cdb_pkt2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt0[i]) cdb_pkt  = wb_to_cdb(slot[i], 1'(i == WB_REQ_LOAD), 1'b0);
      if (gnt2[i]) cdb_pkt2 = wb_to_cdb(slot[i], 1'(i == WB_REQ_LOAD), 1'b0);
    end
    if (br_occ) cdb_pkt2 = wb_to_cdb(br_slot, 1'b0, 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot[i] <= '0;
        age[i]  <= '0;
      end
      occ     <= '0;
      br_slot <= '0;
      br_occ  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_pkt[i].valid && req_ready[i] && !in_kill[i]) begin
          slot[i]          <= req_pkt[i];
          slot[i].br_bmask <= req_pkt[i].br_bmask & ~clr_mask;
          occ[i]           <= 1'b1;
          age[i]           <= '0;
        end else if (!occ[i] || gnt[i] || kill[i]) begin
          occ[i] <= 1'b0;
          age[i] <= '0;
        end else begin
          slot[i].br_bmask <= slot[i].br_bmask & ~clr_mask;
          if (!starved[i]) age[i] <= age[i] + 1'b1;
        end
      end
      br_occ <= br_pkt.valid;
      if (br_pkt.valid) br_slot <= br_pkt;
    end
  end

endmodule
